// File: rtl/tt_pkg.sv
// Shared types and sizes for the truth-table scanner.
package tt_pkg;
  localparam int TT_W  = 128;
  localparam int NIB_N = 32;
  localparam int N_IN  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_EMIT   = 2'd2,
    ST_FINISH = 2'd3
  } tt_state_e;
endpackage

// File: rtl/tt_nib_ser.sv
// 128-bit to 4-bit valid/ready serializer, MSB nibble first.
module tt_nib_ser
  import tt_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [TT_W-1:0] data_i,
  input  logic            ready_i,
  output logic [3:0]      data_o,
  output logic            valid_o,
  output logic            last_o
);
  logic [TT_W-1:0] sr_q;
  logic [4:0]      cnt_q;
  logic            vld_q;
  logic            fire;

  assign fire    = vld_q & ready_i;
  assign data_o  = sr_q[TT_W-1 -: 4];
  assign valid_o = vld_q;
  assign last_o  = fire && (cnt_q == 5'(NIB_N-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else if (load_i) begin
      sr_q  <= data_i;
      cnt_q <= '0;
      vld_q <= 1'b1;
    end else if (fire) begin
      sr_q  <= sr_q << 4;
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'(NIB_N-1)) vld_q <= 1'b0;
    end
  end
endmodule

// File: rtl/tt_scanner.sv
// Walks all 128 input combinations of a 7-input function, records the
// responses into a truth table and streams it out as 32 hex nibbles.
module tt_scanner
  import tt_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] x,
  input  logic            f_in,
  output logic            busy,
  output logic [3:0]      nib_data,
  output logic            nib_valid,
  input  logic            nib_ready,
  output logic            done
);
  tt_state_e       state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [3:0]      hold_q, hold_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic            ser_load, ser_last;

  // x comes straight from the index register, so it holds 127 after a scan.
  assign x    = idx_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      tt_q    <= tt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    tt_d     = tt_q;
    ser_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          hold_d  = '0;
          tt_d    = '0;
        end
      end
      ST_SCAN: begin
        if (hold_q == 4'(SETTLE-1)) begin
          tt_d[idx_q] = f_in;
          hold_d      = '0;
          // Last index: leave for EMIT instead of wrapping back to 0.
          if (idx_q == N_IN'(TT_W-1)) begin
            state_d  = ST_EMIT;
            ser_load = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      ST_EMIT: begin
        if (ser_last) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Loaded from tt_d so the final sample lands in the serializer too.
  tt_nib_ser u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ser_load),
    .data_i  (tt_d),
    .ready_i (nib_ready),
    .data_o  (nib_data),
    .valid_o (nib_valid),
    .last_o  (ser_last)
  );
endmodule

// File: tb/tb_tt_scanner.sv
// Directed bench for tt_scanner with a nibble scoreboard.
module tb_tt_scanner;
  logic       clk, rst_n, start, f_in, busy, nib_valid, nib_ready, done;
  logic [6:0] x;
  logic [3:0] nib_data;
  int         mode;
  int         n_vec = 0;
  int         n_err = 0;

  tt_scanner #(.SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .f_in(f_in),
    .busy(busy), .nib_data(nib_data), .nib_valid(nib_valid),
    .nib_ready(nib_ready), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic fmodel(input int m, input logic [6:0] v);
    case (m)
      1:       return v[0];
      2:       return v[6];
      3:       return (v[0] & v[1]) | (v[0] & v[6]) | (v[1] & v[6]);
      default: return 1'b0;
    endcase
  endfunction

  always_comb f_in = fmodel(mode, x);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input int m, input bit rnd, input bit hold, input bit chk_lat);
    logic [127:0] t;
    logic [3:0]   exp_q[$];
    logic [3:0]   prev_d;
    bit           prev_stall, fin;
    int           n, first;
    mode = m;
    for (int i = 0; i < 128; i++) t[i] = fmodel(m, 7'(i));
    for (int k = 0; k < 32; k++) exp_q.push_back(t[127-4*k -: 4]);
    @(negedge clk); start = 1'b1; nib_ready = 1'b0;
    @(negedge clk); if (!hold) start = 1'b0;
    check("busy_scan", 32'(busy), 32'd1);
    n = 0; first = -1; prev_stall = 0; fin = 0; prev_d = '0;
    while (!fin && n < 4000) begin
      if (nib_valid && first < 0) first = n;
      if (prev_stall) begin
        check("stall_valid", 32'(nib_valid), 32'd1);
        check("stall_data", 32'(nib_data), 32'(prev_d));
      end
      if (done) begin
        check("done_all_nibbles", 32'(exp_q.size()), 32'd0);
        check("done_valid_low", 32'(nib_valid), 32'd0);
        fin = 1;
        prev_stall = 0;
      end else if (nib_valid) begin
        nib_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (nib_ready) begin
          if (exp_q.size() == 0) check("extra_nibble", 32'(nib_data), 32'hdead);
          else check("nibble", 32'(nib_data), 32'(exp_q.pop_front()));
        end
        prev_stall = !nib_ready;
        prev_d     = nib_data;
      end else begin
        nib_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        prev_stall = 0;
      end
      @(negedge clk); n++;
    end
    check("scan_finished", 32'(fin), 32'd1);
    if (chk_lat) check("first_valid_latency", 32'(first), 32'd256);
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_single_pulse", 32'(done), 32'd0);
    check("x_hold", 32'(x), 32'd127);
    nib_ready = 1'b0;
  endtask

  initial begin
    int n;
    mode = 0; start = 0; nib_ready = 0; rst_n = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({x, busy, nib_valid, nib_data, done}), 32'd0);
    rst_n = 1;

    run_scan(0, 0, 0, 0);  // all-zero table
    run_scan(1, 0, 0, 1);  // x[0] -> all 0xA, latency 256
    run_scan(2, 0, 0, 0);  // x[6] -> F upper half, 0 lower
    run_scan(3, 1, 0, 0);  // majority with random backpressure

    // abort mid-scan at index 60
    mode = 3;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    n = 0;
    while (x != 7'd60 && n < 1000) begin @(negedge clk); n++; end
    check("reach_index60", 32'(x), 32'd60);
    rst_n = 0; #1;
    check("async_reset_outputs", 32'({x, busy, nib_valid, nib_data, done}), 32'd0);
    @(negedge clk);
    check("reset_no_done", 32'(done), 32'd0);
    rst_n = 1;
    run_scan(3, 1, 0, 0);

    // start held through a whole scan: one scan, one done, then restart from IDLE
    run_scan(1, 1, 1, 0);
    @(negedge clk);
    check("restart_from_idle", 32'(busy), 32'd1);
    start = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
